// File: rtl/module_detector_error.sv
`default_nettype none
// ============================================================================
// Module      : module_detector_error
// Description : Two-stage registered SECDED syndrome / parity detector placed
//               upstream of the error corrector. Words enter over a
//               valid/ready handshake. The Hamming syndrome, global parity and
//               double-error flag are computed between stage 1 and stage 2.
//               The word is forwarded unchanged together with those flags.
//               Saturating statistics counters track processed words, single
//               errors and double errors.
// Revision    : 1.0 - initial release
// ============================================================================
module module_detector_error #(
    parameter int ANCHO_CONT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  entrada_valida,
    input  logic [7:0]            datos_recibidos,
    output logic                  entrada_lista,
    output logic                  salida_valida,
    input  logic                  salida_lista,
    output logic [7:0]            datos_salida,
    output logic [2:0]            sindrome,
    output logic                  paridad_global,
    output logic                  error_doble,
    input  logic                  limpiar_cont,
    output logic [ANCHO_CONT-1:0] cont_palabras,
    output logic [ANCHO_CONT-1:0] cont_simple,
    output logic [ANCHO_CONT-1:0] cont_doble
);

    localparam logic [ANCHO_CONT-1:0] c_cont_max = {ANCHO_CONT{1'b1}};
    localparam logic [ANCHO_CONT-1:0] c_cont_uno = {{(ANCHO_CONT-1){1'b0}}, 1'b1};

    // Stage 1: captured word
    logic                  r_v1;
    logic [7:0]            r_d1;

    // Stage 2: word plus flags, drives the outputs directly
    logic                  r_v2;
    logic [7:0]            r_d2;
    logic [2:0]            r_sind2;
    logic                  r_par2;
    logic                  r_dbl2;

    // Statistics counters
    logic [ANCHO_CONT-1:0] r_cont_pal;
    logic [ANCHO_CONT-1:0] r_cont_sim;
    logic [ANCHO_CONT-1:0] r_cont_dbl;

    // Handshake and flag computation
    logic                  w_avanza2;
    logic                  w_acepta;
    logic [2:0]            w_sind;
    logic                  w_par;
    logic                  w_dbl;

    // S1 moves forward when S2 is empty or is being consumed this cycle.
    // Input ready depends only on registered valids and downstream ready.
    always_comb begin
        w_avanza2     = r_v1 & (~r_v2 | salida_lista);
        entrada_lista = ~r_v1 | w_avanza2;
        w_acepta      = entrada_valida & entrada_lista;
    end

    // Syndrome and parity of the word sitting in S1; bit i is position i+1
    always_comb begin
        w_sind[0] = r_d1[0] ^ r_d1[2] ^ r_d1[4] ^ r_d1[6];
        w_sind[1] = r_d1[1] ^ r_d1[2] ^ r_d1[5] ^ r_d1[6];
        w_sind[2] = r_d1[3] ^ r_d1[4] ^ r_d1[5] ^ r_d1[6];
        w_par     = ^r_d1;
        w_dbl     = (w_sind != 3'b000) & ~w_par;
    end

    // Stage 1 register: capture on handshake, empty when its word advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_d1 <= 8'h00;
        end else if (w_acepta) begin
            r_v1 <= 1'b1;
            r_d1 <= datos_recibidos;
        end else if (w_avanza2) begin
            r_v1 <= 1'b0;
        end
    end

    // Stage 2 register: load on advance, drop valid once consumed; otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_d2    <= 8'h00;
            r_sind2 <= 3'b000;
            r_par2  <= 1'b0;
            r_dbl2  <= 1'b0;
        end else if (w_avanza2) begin
            r_v2    <= 1'b1;
            r_d2    <= r_d1;
            r_sind2 <= w_sind;
            r_par2  <= w_par;
            r_dbl2  <= w_dbl;
        end else if (salida_lista) begin
            r_v2    <= 1'b0;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || limpiar_cont) begin
            r_cont_pal <= '0;
            r_cont_sim <= '0;
            r_cont_dbl <= '0;
        end else if (w_avanza2) begin
            if (r_cont_pal != c_cont_max) begin
                r_cont_pal <= r_cont_pal + c_cont_uno;
            end
            if (w_par && (r_cont_sim != c_cont_max)) begin
                r_cont_sim <= r_cont_sim + c_cont_uno;
            end
            if (w_dbl && (r_cont_dbl != c_cont_max)) begin
                r_cont_dbl <= r_cont_dbl + c_cont_uno;
            end
        end
    end

    // Outputs come straight from registers
    always_comb begin
        salida_valida  = r_v2;
        datos_salida   = r_d2;
        sindrome       = r_sind2;
        paridad_global = r_par2;
        error_doble    = r_dbl2;
        cont_palabras  = r_cont_pal;
        cont_simple    = r_cont_sim;
        cont_doble     = r_cont_dbl;
    end

endmodule
`default_nettype wire
